// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: mode-0 SPI transaction sequencer driving the latch datapath strobes
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start, abort      launch a transaction (IDLE only) / cut a running one short
//   cfg_div           sclk half-period in clk cycles (0 behaves as 1)
//   cfg_ncycles       number of sclk cycles in the transaction
//   sclk, ss_n        SPI pad clock (idles low) and active-low chip select
//   sclk_en           datapath shift enable, high for the whole TRANSFER phase
//   latchout_en       1-cycle strobe: datapath launches the next MOSI bits
//   latchin_en        1-cycle strobe: datapath samples MISO
//   setup_rst         1-cycle datapath clear
//   loadtxdata_en     1-cycle tx string load
//   busy, done        transaction in progress / 1-cycle completion pulse
//   edge_count        sclk rising edges issued in the current transaction
module spi_xfer_ctrl #(
    parameter int DIVW    = 4,
    parameter int CS_LEAD = 2,
    parameter int CS_LAG  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [DIVW-1:0] cfg_div,
    input  logic [9:0]      cfg_ncycles,
    output logic            sclk,
    output logic            ss_n,
    output logic            sclk_en,
    output logic            latchout_en,
    output logic            latchin_en,
    output logic            setup_rst,
    output logic            loadtxdata_en,
    output logic            busy,
    output logic            done,
    output logic [9:0]      edge_count
);
    typedef enum logic [2:0] {IDLE, SETUP, LOAD, LEAD, XFER, LAG, DONE} state_t;
    state_t st, st_nxt;
    logic [DIVW-1:0] div_r, div_nxt, hcnt, hcnt_nxt;
    logic [9:0] n_r, n_nxt, ec_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic wrap, sclk_nxt, lin_nxt, lout_nxt;
    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= IDLE;
            div_r         <= DIVW'(1);
            n_r           <= '0;
            hcnt          <= '0;
            cnt           <= '0;
            sclk          <= 1'b0;
            ss_n          <= 1'b1;
            sclk_en       <= 1'b0;
            latchout_en   <= 1'b0;
            latchin_en    <= 1'b0;
            setup_rst     <= 1'b0;
            loadtxdata_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            edge_count    <= '0;
        end else begin
            st            <= st_nxt;
            div_r         <= div_nxt;
            n_r           <= n_nxt;
            hcnt          <= hcnt_nxt;
            cnt           <= cnt_nxt;
            sclk          <= sclk_nxt;
            ss_n          <= !(st_nxt inside {LEAD, XFER, LAG});
            sclk_en       <= st_nxt == XFER;
            latchout_en   <= lout_nxt;
            latchin_en    <= lin_nxt;
            setup_rst     <= st_nxt == SETUP;
            loadtxdata_en <= st_nxt == LOAD;
            busy          <= !(st_nxt inside {IDLE, DONE});
            done          <= st_nxt == DONE;
            edge_count    <= ec_nxt;
        end
    end
    // Outputs are registered, so every value below is what the outputs will
    // show in the state being entered.
    always_comb begin
        st_nxt   = st;
        div_nxt  = div_r;
        n_nxt    = n_r;
        hcnt_nxt = hcnt;
        cnt_nxt  = cnt;
        ec_nxt   = edge_count;
        sclk_nxt = 1'b0;
        lin_nxt  = 1'b0;
        lout_nxt = 1'b0;
        wrap     = hcnt == div_r - DIVW'(1);
        case (st)
            IDLE: if (start) begin
                st_nxt  = SETUP;
                div_nxt = (cfg_div == '0) ? DIVW'(1) : cfg_div;
                n_nxt   = cfg_ncycles;
                ec_nxt  = '0;
            end
            SETUP: st_nxt = LOAD;
            LOAD: begin
                st_nxt  = LEAD;
                cnt_nxt = '0;
            end
            LEAD: if (cnt == 8'(CS_LEAD - 1)) begin
                st_nxt   = (n_r == '0) ? LAG : XFER;
                hcnt_nxt = '0;
                cnt_nxt  = '0;
            end else begin
                cnt_nxt = cnt + 8'd1;
            end
            XFER: begin
                hcnt_nxt = wrap ? '0 : hcnt + DIVW'(1);
                sclk_nxt = wrap ? ~sclk : sclk;
                if (wrap && !sclk) begin
                    lin_nxt = 1'b1;
                    ec_nxt  = edge_count + 10'd1;
                end else if (wrap && edge_count == n_r) begin
                    // fall after the final rise ends the transfer without a launch
                    st_nxt  = LAG;
                    cnt_nxt = '0;
                end else if (wrap) begin
                    lout_nxt = 1'b1;
                end
            end
            LAG: begin
                st_nxt  = (cnt == 8'(CS_LAG - 1)) ? DONE : LAG;
                cnt_nxt = cnt + 8'd1;
            end
            DONE: st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
        // first bit launch lands on the last LEAD cycle
        if (st_nxt == LEAD && cnt_nxt == 8'(CS_LEAD - 1) && n_r != '0)
            lout_nxt = 1'b1;
        if (abort && st inside {SETUP, LOAD, LEAD, XFER}) begin
            st_nxt   = LAG;
            cnt_nxt  = '0;
            sclk_nxt = 1'b0;
            lin_nxt  = 1'b0;
            lout_nxt = 1'b0;
            ec_nxt   = edge_count;
        end
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed self-checking bench for spi_xfer_ctrl
module tb_spi_xfer_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] cfg_div = '0;
    logic [9:0] cfg_ncycles = '0;
    logic       sclk, ss_n, sclk_en, latchout_en, latchin_en, setup_rst, loadtxdata_en, busy, done;
    logic [9:0] edge_count;
    int checks = 0;
    int errors = 0;
    int first_setup, first_load, first_ssn, first_lout, done_at, n_lin, n_lout, both;
    int run, max_run, toggles, en_cyc, abort_cyc, post_abort, sclk_after, ssn_lag, ec_done;
    int busy_done, ssn_done;
    logic prev_sclk;

    spi_xfer_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_div(cfg_div),
        .cfg_ncycles(cfg_ncycles), .sclk(sclk), .ss_n(ss_n), .sclk_en(sclk_en),
        .latchout_en(latchout_en), .latchin_en(latchin_en), .setup_rst(setup_rst),
        .loadtxdata_en(loadtxdata_en), .busy(busy), .done(done), .edge_count(edge_count)
    );

    always #5 clk = ~clk;

    // Launches one transaction and records what it observed, cycle index relative to t0.
    task automatic launch(input logic [3:0] d, input logic [9:0] n, input logic abort_with_start,
                          input int abort_after, input int restart_at, input int rst_at);
        first_setup = -1; first_load = -1; first_ssn = -1; first_lout = -1; done_at = -1;
        n_lin = 0; n_lout = 0; both = 0; run = 0; max_run = 0; toggles = 0; en_cyc = 0;
        abort_cyc = -1; post_abort = 0; sclk_after = -1; ssn_lag = -1; ec_done = -1;
        busy_done = -1; ssn_done = -1; prev_sclk = 1'b0;
        @(negedge clk);
        cfg_div = d; cfg_ncycles = n; start = 1'b1; abort = abort_with_start;
        for (int i = 1; i < 3000; i++) begin
            @(negedge clk);
            start = (i == restart_at);
            abort = 1'b0;
            cfg_div = 4'd7;
            cfg_ncycles = 10'd3;
            if (i == rst_at) begin
                rst = 1'b1;
                break;
            end
            if (setup_rst && first_setup < 0) first_setup = i;
            if (loadtxdata_en && first_load < 0) first_load = i;
            if (!ss_n && first_ssn < 0) first_ssn = i;
            if (latchout_en && first_lout < 0) first_lout = i;
            n_lin += int'(latchin_en);
            n_lout += int'(latchout_en);
            if (latchin_en && latchout_en) both++;
            run = sclk ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (sclk != prev_sclk) toggles++;
            prev_sclk = sclk;
            if (sclk_en) en_cyc++;
            if (abort_cyc >= 0 && i > abort_cyc && (latchin_en || latchout_en)) post_abort++;
            if (abort_cyc >= 0 && i == abort_cyc + 1) sclk_after = int'(sclk);
            if (abort_cyc >= 0 && i == abort_cyc + 2) ssn_lag = int'(ss_n);
            if (abort_after > 0 && latchin_en && n_lin == abort_after && abort_cyc < 0) begin
                abort = 1'b1;
                abort_cyc = i;
            end
            if (done) begin
                done_at = i; ec_done = int'(edge_count); busy_done = int'(busy); ssn_done = int'(ss_n);
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({sclk, ss_n, sclk_en, latchout_en, latchin_en, setup_rst, loadtxdata_en, busy, done} !== 9'b010000000
                || edge_count !== 10'd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %b ec=%0d want 010000000 ec=0", i,
                         {sclk, ss_n, sclk_en, latchout_en, latchin_en, setup_rst, loadtxdata_en, busy, done}, edge_count);
            end
        end
    endtask

    task automatic test_basic;
        launch(4'd2, 10'd8, 1'b0, 0, 0, 0);
        checks++; if (first_setup !== 1) begin errors++; $display("FAIL basic_setup_rst: got %0d want 1", first_setup); end
        checks++; if (first_load !== 2) begin errors++; $display("FAIL basic_load: got %0d want 2", first_load); end
        checks++; if (first_ssn !== 3) begin errors++; $display("FAIL basic_ss_low: got %0d want 3", first_ssn); end
        checks++; if (first_lout !== 4) begin errors++; $display("FAIL basic_first_lout: got %0d want 4", first_lout); end
        checks++; if (n_lin !== 8) begin errors++; $display("FAIL basic_latchin_count: got %0d want 8", n_lin); end
        checks++; if (n_lout !== 8) begin errors++; $display("FAIL basic_latchout_count: got %0d want 8", n_lout); end
        checks++; if (done_at !== 39) begin errors++; $display("FAIL basic_done_at: got %0d want 39", done_at); end
        checks++; if (ec_done !== 8) begin errors++; $display("FAIL basic_edge_count: got %0d want 8", ec_done); end
        checks++; if (en_cyc !== 32) begin errors++; $display("FAIL basic_sclk_en_cycles: got %0d want 32", en_cyc); end
        checks++; if (max_run !== 2 || toggles !== 16) begin errors++; $display("FAIL basic_sclk_shape: got run=%0d tog=%0d want run=2 tog=16", max_run, toggles); end
        checks++; if (both !== 0) begin errors++; $display("FAIL basic_exclusive: got %0d want 0", both); end
        checks++; if (busy_done !== 0 || ssn_done !== 1) begin errors++; $display("FAIL basic_done_outputs: got busy=%0d ss_n=%0d want busy=0 ss_n=1", busy_done, ssn_done); end
        @(negedge clk);
        checks++; if (edge_count !== 10'd8 || busy !== 1'b0) begin errors++; $display("FAIL basic_hold: got ec=%0d busy=%0d want ec=8 busy=0", edge_count, busy); end
    endtask

    task automatic test_div_zero;
        // 2*div*N = 2 transfer cycles after LEAD ends at t0+4, then 2 LAG cycles
        launch(4'd0, 10'd1, 1'b0, 0, 0, 0);
        checks++; if (max_run !== 1 || toggles !== 2) begin errors++; $display("FAIL div0_sclk: got run=%0d tog=%0d want run=1 tog=2", max_run, toggles); end
        checks++; if (done_at !== 9) begin errors++; $display("FAIL div0_done_at: got %0d want 9", done_at); end
        checks++; if (n_lin !== 1 || n_lout !== 1) begin errors++; $display("FAIL div0_strobes: got in=%0d out=%0d want in=1 out=1", n_lin, n_lout); end
        checks++; if (ec_done !== 1) begin errors++; $display("FAIL div0_edge_count: got %0d want 1", ec_done); end
    endtask

    task automatic test_zero_cycles;
        // abort raised together with start must be ignored
        launch(4'd2, 10'd0, 1'b1, 0, 0, 0);
        checks++; if (first_setup !== 1) begin errors++; $display("FAIL n0_start_wins: got %0d want 1", first_setup); end
        checks++; if (toggles !== 0 || en_cyc !== 0) begin errors++; $display("FAIL n0_no_sclk: got tog=%0d en=%0d want 0 0", toggles, en_cyc); end
        checks++; if (n_lin !== 0 || n_lout !== 0) begin errors++; $display("FAIL n0_no_strobes: got in=%0d out=%0d want 0 0", n_lin, n_lout); end
        checks++; if (done_at !== 7) begin errors++; $display("FAIL n0_done_at: got %0d want 7", done_at); end
        checks++; if (ec_done !== 0) begin errors++; $display("FAIL n0_edge_count: got %0d want 0", ec_done); end
    endtask

    task automatic test_abort;
        launch(4'd3, 10'd16, 1'b0, 5, 0, 0);
        checks++; if (sclk_after !== 0) begin errors++; $display("FAIL abort_sclk_low: got %0d want 0", sclk_after); end
        checks++; if (ssn_lag !== 0) begin errors++; $display("FAIL abort_lag_ss: got %0d want 0", ssn_lag); end
        checks++; if (done_at !== abort_cyc + 3 || abort_cyc < 0) begin errors++; $display("FAIL abort_done_at: got %0d want %0d", done_at, abort_cyc + 3); end
        checks++; if (ec_done !== 5 || n_lin !== 5) begin errors++; $display("FAIL abort_edge_count: got ec=%0d in=%0d want 5 5", ec_done, n_lin); end
        checks++; if (post_abort !== 0) begin errors++; $display("FAIL abort_no_strobes: got %0d want 0", post_abort); end
        checks++; if (ssn_done !== 1) begin errors++; $display("FAIL abort_ss_release: got %0d want 1", ssn_done); end
    endtask

    task automatic test_back_to_back;
        int extra;
        launch(4'd1, 10'd4, 1'b0, 0, 8, 0);
        checks++; if (done_at !== 15) begin errors++; $display("FAIL b2b_done_at: got %0d want 15", done_at); end
        checks++; if (first_setup !== 1 || ec_done !== 4) begin errors++; $display("FAIL b2b_single: got setup=%0d ec=%0d want 1 4", first_setup, ec_done); end
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy || setup_rst) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_no_queue: got %0d busy cycles want 0", extra); end
    endtask

    task automatic test_reset_mid;
        launch(4'd2, 10'd8, 1'b0, 0, 0, 12);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({sclk, ss_n, sclk_en, latchout_en, latchin_en, setup_rst, loadtxdata_en, busy, done} !== 9'b010000000
            || edge_count !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid: got %b ec=%0d want 010000000 ec=0",
                     {sclk, ss_n, sclk_en, latchout_en, latchin_en, setup_rst, loadtxdata_en, busy, done}, edge_count);
        end
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0 || ss_n !== 1'b1) begin errors++; $display("FAIL reset_mid_idle: got busy=%0d ss_n=%0d want 0 1", busy, ss_n); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_div_zero;
        test_zero_cycles;
        test_abort;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
